// File: rtl/inst_fetch.sv
// LEGv8 instruction fetch: PC, instruction memory with a load port, and IDLE/RUN/HALT run control.
// Optional IF_BOUND_CHECK_EN faults on a next-pc beyond the memory instead of wrapping.
`ifndef INST_SIZE
`define INST_SIZE 32
`endif
`ifndef WORD
`define WORD 64
`endif

module inst_fetch #(
  parameter int                     IMEM_DEPTH = 64,
  parameter int                     IMEM_AW    = $clog2(IMEM_DEPTH),
  parameter logic [`INST_SIZE-1:0]  HALT_INST  = 32'hD4400000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   load_en,
  input  logic [IMEM_AW-1:0]     load_addr,
  input  logic [`INST_SIZE-1:0]  load_data,
  input  logic                   stall,
  input  logic                   uncond_branch,
  input  logic                   branch,
  input  logic                   zero,
  input  logic [`WORD-1:0]       ex_data,
  output logic [`WORD-1:0]       pc,
  output logic [`INST_SIZE-1:0]  inst,
  output logic                   running,
  output logic                   halted,
  output logic                   err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [`WORD-1:0]        pc_reg;
  logic                    running_reg;
  logic                    halted_reg;

  logic [`INST_SIZE-1:0]   imem [IMEM_DEPTH];
  logic [IMEM_AW-1:0]      word_addr;
  logic [`INST_SIZE-1:0]   fetched;
  logic                    taken;
  logic [`WORD-1:0]        target;
  logic [`WORD-1:0]        pc_next;
  logic                    halt_hit;

  // Without the bound check the word address simply wraps modulo the memory size.
  assign word_addr = pc_reg[IMEM_AW+1:2];
  assign fetched   = imem[word_addr];

  always_comb begin
    taken    = uncond_branch | (branch & zero);
    target   = pc_reg + (ex_data << 2);
    pc_next  = taken ? target : pc_reg + `WORD'(4);
    halt_hit = (fetched == HALT_INST);
  end

`ifdef IF_BOUND_CHECK_EN
  localparam logic [`WORD-1:0] PC_LIMIT = `WORD'(IMEM_DEPTH) * `WORD'(4);
  logic err_reg;
  logic bound_fault;
  assign bound_fault = (pc_next >= PC_LIMIT);
  assign err         = err_reg;
`else
  assign err = 1'b0;
`endif

  // Contents are deliberately not reset so a program survives rst_n.
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && load_en) begin
      imem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pc_reg      <= '0;
      running_reg <= 1'b0;
      halted_reg  <= 1'b0;
`ifdef IF_BOUND_CHECK_EN
      err_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
            pc_reg      <= '0;
          end
        end
        RUN: begin
          // Stall freezes everything, including branch and halt decisions.
          if (!stall) begin
`ifdef IF_BOUND_CHECK_EN
            if (bound_fault) begin
              err_reg     <= 1'b1;
              state_reg   <= HALT;
              running_reg <= 1'b0;
              halted_reg  <= 1'b1;
            end else
`endif
            if (halt_hit) begin
              state_reg   <= HALT;
              running_reg <= 1'b0;
              halted_reg  <= 1'b1;
            end else begin
              pc_reg <= pc_next;
            end
          end
        end
        HALT: begin
          if (start) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
            halted_reg  <= 1'b0;
            pc_reg      <= '0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          running_reg <= 1'b0;
          halted_reg  <= 1'b0;
          pc_reg      <= '0;
        end
      endcase
    end
  end

  assign pc      = pc_reg;
  assign inst    = (state_reg == RUN) ? fetched : '0;
  assign running = running_reg;
  assign halted  = halted_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector tables, hand-written reset/halt/bound sequences,
// and randomized stimulus checked against a behavioural model of the fetch rules.
module tb_inst_fetch;
  localparam int          DEPTH = 64;
  localparam logic [31:0] HLT   = 32'hD4400000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic        stall;
  logic        uncond_branch;
  logic        branch;
  logic        zero;
  logic [63:0] ex_data;
  logic [63:0] pc;
  logic [31:0] inst;
  logic        running;
  logic        halted;
  logic        err;

  inst_fetch #(.IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .stall(stall),
    .uncond_branch(uncond_branch), .branch(branch), .zero(zero),
    .ex_data(ex_data), .pc(pc), .inst(inst), .running(running),
    .halted(halted), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        stall;
    logic        uncond;
    logic        brn;
    logic        zero;
    logic [63:0] ex;
    logic [63:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_run;
    logic        exp_halt;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: mode 0 = idle, 1 = run, 2 = halt.
  logic [31:0] m_mem [DEPTH];
  int          m_mode;
  logic [63:0] m_pc;
  logic        m_err;

  function automatic vec_t mk(input logic s, input logic u, input logic b, input logic z,
                              input logic [63:0] ex, input logic [63:0] p,
                              input logic [31:0] i, input logic r, input logic h);
    vec_t v;
    v.stall = s; v.uncond = u; v.brn = b; v.zero = z; v.ex = ex;
    v.exp_pc = p; v.exp_inst = i; v.exp_run = r; v.exp_halt = h;
    return v;
  endfunction

  function automatic logic [31:0] fill_word(input int i);
    return 32'h9100_0000 | 32'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    start = 0; load_en = 0; load_addr = '0; load_data = '0;
    stall = 0; uncond_branch = 0; branch = 0; zero = 0; ex_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vecs(input string tag);
    foreach (vecs[k]) begin
      stall = vecs[k].stall; uncond_branch = vecs[k].uncond;
      branch = vecs[k].brn; zero = vecs[k].zero; ex_data = vecs[k].ex;
      tick();
      chk($sformatf("%s[%0d].pc", tag, k), pc, vecs[k].exp_pc);
      chk($sformatf("%s[%0d].inst", tag, k), 64'(inst), 64'(vecs[k].exp_inst));
      chk($sformatf("%s[%0d].running", tag, k), 64'(running), 64'(vecs[k].exp_run));
      chk($sformatf("%s[%0d].halted", tag, k), 64'(halted), 64'(vecs[k].exp_halt));
      $display("%s vec %0d: pc=%h inst=%h running=%b halted=%b", tag, k, pc, inst, running, halted);
    end
    clear_inputs();
    vecs.delete();
  endtask

  task automatic async_reset(input string tag);
    rst_n = 0;
    #1;
    chk({tag, ".pc"}, pc, 64'd0);
    chk({tag, ".inst"}, 64'(inst), 64'd0);
    chk({tag, ".running"}, 64'(running), 64'd0);
    chk({tag, ".halted"}, 64'(halted), 64'd0);
    chk({tag, ".err"}, 64'(err), 64'd0);
    clear_inputs();
    tick();
    rst_n = 1;
    m_mode = 0; m_pc = '0; m_err = 0;
  endtask

  function automatic logic [31:0] m_word(input logic [63:0] addr);
    return m_mem[int'((addr >> 2) % 64'(DEPTH))];
  endfunction

  function automatic logic [31:0] m_inst();
    return (m_mode == 1) ? m_word(m_pc) : 32'd0;
  endfunction

  task automatic model_step();
    logic [63:0] nxt;
    case (m_mode)
      0: begin
        if (load_en) m_mem[int'(load_addr)] = load_data;
        if (start) begin m_mode = 1; m_pc = '0; end
      end
      1: begin
        if (!stall) begin
          nxt = (uncond_branch || (branch && zero)) ? m_pc + ex_data * 64'd4 : m_pc + 64'd4;
`ifdef IF_BOUND_CHECK_EN
          if (nxt >= 64'(DEPTH * 4)) begin
            m_err = 1; m_mode = 2;
          end else
`endif
          if (m_word(m_pc) == HLT) m_mode = 2;
          else m_pc = nxt;
        end
      end
      default: begin
        if (start) begin m_mode = 1; m_pc = '0; end
      end
    endcase
  endtask

  task automatic model_compare(input int c);
    chk($sformatf("rnd[%0d].pc", c), pc, m_pc);
    chk($sformatf("rnd[%0d].inst", c), 64'(inst), 64'(m_inst()));
    chk($sformatf("rnd[%0d].running", c), 64'(running), 64'(m_mode == 1));
    chk($sformatf("rnd[%0d].halted", c), 64'(halted), 64'(m_mode == 2));
    chk($sformatf("rnd[%0d].err", c), 64'(err), 64'(m_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int off;
    clear_inputs();
    m_mode = 0; m_pc = '0; m_err = 0;
    rst_n = 1;
    #2;
    async_reset("reset");

    // Program A: two ALU words followed by HLT.
    load_en = 1;
    load_addr = 6'd0; load_data = 32'h8B09026A; tick();
    load_addr = 6'd1; load_data = 32'hCB0A028B; tick();
    load_addr = 6'd2; load_data = HLT;          tick();
    clear_inputs();
    chk("idle.pc", pc, 64'd0);
    chk("idle.inst", 64'(inst), 64'd0);
    chk("idle.running", 64'(running), 64'd0);
    start = 1; tick(); start = 0;
    chk("start.pc", pc, 64'd0);
    chk("start.inst", 64'(inst), 64'h8B09026A);
    chk("start.running", 64'(running), 64'd1);
    $display("progA start: pc=%h inst=%h", pc, inst);

    vecs.push_back(mk(0, 0, 0, 0, 64'd0, 64'd4, 32'hCB0A028B, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 64'd0, 64'd8, HLT, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 64'd0, 64'd8, 32'd0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 64'd3, 64'd8, 32'd0, 0, 1));
    apply_vecs("progA");

    // Loads in HALT are ignored; start restarts from pc 0.
    load_en = 1; load_addr = 6'd0; load_data = 32'hDEADBEEF; tick(); clear_inputs();
    chk("halt.hold_pc", pc, 64'd8);
    start = 1; tick(); start = 0;
    chk("restart.pc", pc, 64'd0);
    chk("restart.inst", 64'(inst), 64'h8B09026A);
    chk("restart.running", 64'(running), 64'd1);
    chk("restart.halted", 64'(halted), 64'd0);
    $display("progA restart: pc=%h inst=%h", pc, inst);

    async_reset("rst_run");

    // Fill every word; the final write coincides with start.
    for (int i = 0; i < DEPTH; i++) begin
      load_en = 1; load_addr = 6'(i); load_data = fill_word(i); start = (i == DEPTH - 1);
      tick();
    end
    clear_inputs();
    chk("fill_start.pc", pc, 64'd0);
    chk("fill_start.inst", 64'(inst), 64'(fill_word(0)));
    chk("fill_start.running", 64'(running), 64'd1);

    vecs.push_back(mk(0, 1, 0, 0, 64'd63, 64'd252, fill_word(63), 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, -64'd63, 64'd0, fill_word(0), 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 64'd9, 64'd4, fill_word(1), 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 64'd0, 64'd8, fill_word(2), 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 64'd0, 64'd12, fill_word(3), 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 64'd0, 64'd16, fill_word(4), 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 64'd0, 64'd20, fill_word(5), 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 64'hFFFFFFFFFFFFFFFB, 64'd0, fill_word(0), 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 64'd8, 64'd32, fill_word(8), 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, -64'd7, 64'd4, fill_word(1), 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 64'd2, 64'd8, fill_word(2), 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, -64'd1, 64'd4, fill_word(1), 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 64'd2, 64'd12, fill_word(3), 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 64'd5, 64'd12, fill_word(3), 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 64'd5, 64'd12, fill_word(3), 1, 0));
    vecs.push_back(mk(1, 1, 1, 1, 64'd5, 64'd12, fill_word(3), 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 64'd0, 64'd16, fill_word(4), 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 64'hC000000000000001, 64'd20, fill_word(5), 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, -64'd1, 64'd16, fill_word(4), 1, 0));
    apply_vecs("branch");

    async_reset("rst_mid");
    start = 1; tick(); start = 0;
    chk("rerun.pc", pc, 64'd0);
    chk("rerun.inst", 64'(inst), 64'(fill_word(0)));
    tick();
    chk("rerun.pc4", pc, 64'd4);
    uncond_branch = 1; ex_data = 64'd64; tick(); clear_inputs();
`ifdef IF_BOUND_CHECK_EN
    chk("bound.err", 64'(err), 64'd1);
    chk("bound.halted", 64'(halted), 64'd1);
    chk("bound.pc", pc, 64'd4);
    chk("bound.inst", 64'(inst), 64'd0);
`else
    chk("wrap.pc", pc, 64'd260);
    chk("wrap.inst", 64'(inst), 64'(fill_word(1)));
    chk("wrap.err", 64'(err), 64'd0);
`endif
    $display("far branch: pc=%h inst=%h err=%b halted=%b", pc, inst, err, halted);

    // Randomized run against the behavioural model.
    async_reset("rst_rnd");
    for (int i = 0; i < DEPTH; i++) begin
      load_en = 1; load_addr = 6'(i);
      load_data = ($urandom_range(0, 15) == 0) ? HLT : $urandom;
      model_step(); tick(); model_compare(-1);
    end
    clear_inputs();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset($sformatf("rnd_rst[%0d]", c));
        model_compare(c);
      end else begin
        start = ($urandom_range(0, 7) == 0);
        load_en = ($urandom_range(0, 3) == 0);
        load_addr = 6'($urandom);
        load_data = ($urandom_range(0, 15) == 0) ? HLT : $urandom;
        stall = ($urandom_range(0, 3) == 0);
        uncond_branch = ($urandom_range(0, 7) == 0);
        branch = ($urandom_range(0, 3) == 0);
        zero = 1'($urandom_range(0, 1));
        off = int'($urandom_range(0, 12)) - 6;
        ex_data = 64'(longint'(off));
        model_step();
        tick();
        model_compare(c);
        $display("rnd %0d: pc=%h inst=%h running=%b halted=%b err=%b", c, pc, inst, running, halted, err);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch block for the LEGv8 single-cycle datapath, the producer of the 32-bit instruction that the decode stage consumes. It holds the program counter, contains the instruction memory and a program-load port, and returns the current instruction combinationally. The next PC is either PC+4 or a branch target formed from the sign-extended offset that decode returns. A small run-control FSM sequences the block through load, run and halt.

## Interface
- IMEM_DEPTH, 64: instruction memory depth in 32-bit words; power of two.
- IMEM_AW, $clog2(IMEM_DEPTH): word-address width.
- HALT_INST, 32'hD4400000: encoding that stops fetch (HLT #0).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  IDLE/HALT→RUN request, single-cycle pulse.
- load_en  in  1  instruction memory write strobe; honoured only in IDLE.
- load_addr  in  IMEM_AW  word address for load.
- load_data  in  `INST_SIZE  instruction word to write.
- stall  in  1  hold PC this cycle.
- uncond_branch  in  1  B taken unconditionally.
- branch  in  1  conditional branch (CBZ/CBNZ), taken when zero=1.
- zero  in  1  branch condition from execute.
- ex_data  in  `WORD  sign-extended word offset from decode.
- pc  out  `WORD  current program counter, byte address.
- inst  out  `INST_SIZE  current instruction; 0 unless in RUN.
- running  out  1  state is RUN.
- halted  out  1  state is HALT.
- err  out  1  sticky out-of-range fault (only with bound check compiled in).

## Operation
- FSM states: IDLE (reset state), RUN, HALT.
- IDLE: load_en writes imem[load_addr] <= load_data on the clock edge. start → RUN; pc stays 0.
- RUN: inst = imem[pc[IMEM_AW+1:2]], combinational asynchronous read. Each edge with stall=0:
  - if uncond_branch | (branch & zero): pc <= pc + (ex_data << 2), 64-bit, wraps modulo 2^64;
  - otherwise pc <= pc + 4.
- RUN with stall=1: pc and state hold; branch inputs are ignored. Stall takes priority over both branch and halt.
- RUN with inst == HALT_INST and stall=0: → HALT; pc holds at the HLT address.
- HALT: inst forced 0, pc holds. start → RUN with pc <= 0.
- load_en outside IDLE is ignored. start in RUN is ignored.
- load_en and start in the same IDLE cycle: the write is performed, then the state moves to RUN. The written word is visible from the next cycle.
- ex_data bits that are shifted out are discarded. pc[1:0] is always 00.
- Instruction memory contents are not reset. Reset clears only pc, the state, halted and err.

## Timing
- Reset values: pc=0, inst=0, running=0, halted=0, err=0, state IDLE.
- Reset is asynchronous. Asserting it mid-RUN forces every output to its reset value immediately.
- inst has zero-cycle latency from pc; there is no read pipeline.
- pc, running and halted update on the rising clk edge following the qualifying input, which is sampled at that edge.
- Branch decision: branch inputs in the cycle where pc=P take effect so that pc = target on the next edge.

## Configuration
- IF_BOUND_CHECK_EN defined:
  - In RUN, a next-pc at or above IMEM_DEPTH*4 sets err=1 (sticky until reset) and moves the FSM to HALT. pc keeps the faulting instruction's address; the bad target is not loaded.
  - This check takes priority over halt detection.
- Undefined: err is tied 0. The word address is pc[IMEM_AW+1:2], so fetch wraps modulo the memory size.

## Test plan
- Reset, load 0x8B09026A/0xCB0A028B/HALT_INST at 0..2, start → inst sequence 0x8B09026A, 0xCB0A028B, HALT_INST at pc 0, 4, 8; then halted=1, pc=8, inst=0.
- Branch at pc=20 with uncond_branch=1 and ex_data=64'hFFFFFFFFFFFFFFFB → next pc=0. Branch at pc=0 with ex_data=64'd8 → pc=32.
- branch=1, zero=0 at pc=4 → pc=8. Same with zero=1 and ex_data=2 → pc=12.
- stall=1 for 3 cycles at pc=12 with uncond_branch=1 → pc stays 12 throughout. After release with branch inputs low → pc=16.
- Assert rst_n=0 mid-RUN at pc=16 → pc=0, inst=0, running=0 immediately. Memory retains its contents: start re-runs the same program.
- With IF_BOUND_CHECK_EN and IMEM_DEPTH=64, B with ex_data=64 from pc=4 → err=1, halted=1, pc=4. Without the macro → pc=260, inst=imem[1].
